// File: rtl/if_arb_pkg.sv
// if_arb_pkg: shared definitions for shared-unit arbiters.
//   - arb_state_e : controller states (IDLE, ISSUE, SETTLE, RESP)
//   - clog2()     : ID width helper (minimum 1 bit)
//   - rr_pick()   : round-robin search from a pointer, wrapping at nreq
package if_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Searches ptr, ptr+1, ... (mod nreq). Iterating from the far end lets the
  // nearest asserted line overwrite the result last.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int ptr, input int nreq);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.idx   = 32'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: combinational round-robin picker.
// Ports:
//   valid [NREQ]  request lines
//   ptr   [ID_W]  highest-priority index this cycle
//   grant [NREQ]  one-hot winner (zero when nothing is valid)
//   idx   [ID_W]  winner index
//   found         at least one line valid
module rr_arbiter_core
  import if_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    pick                  = rr_pick(valid_ext, int'(ptr), NREQ);
    idx                   = ID_W'(pick.idx);
    found                 = pick.found;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = pick.found && (idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/if_unit_arbiter.sv
// if_unit_arbiter: shares one combinational compare/update unit among NREQ
// requesters with round-robin arbitration. Operands are captured, driven to
// the unit, held UNIT_LAT extra cycles, and the result is returned on one
// valid/ready response channel tagged with the requester ID.
// Ports:
//   CLK, RST_N (async, active-low)
//   REQ_VALID/REQ_READY/REQ_A/REQ_B : packed per-requester request channel
//   UNIT_A/UNIT_B/UNIT_XOUT         : shared unit operands and result
//   RSP_VALID/RSP_READY/RSP_ID/RSP_DATA : response channel
// Optional build macro IF_UNIT_ARBITER_STATS_EN adds STATS_CLR (in) and
// GRANT_CNT (out, 16-bit saturating grant counter per requester).
module if_unit_arbiter
  import if_arb_pkg::*;
#(
  parameter int  NREQ     = 4,
  parameter int  AW       = 8,
  parameter int  BW       = 16,
  parameter int  UNIT_LAT = 1,
  localparam int ID_W     = clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*AW-1:0]   REQ_A,
  input  logic [NREQ*BW-1:0]   REQ_B,
  output logic [AW-1:0]        UNIT_A,
  output logic [BW-1:0]        UNIT_B,
  input  logic [BW-1:0]        UNIT_XOUT,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ID_W-1:0]      RSP_ID,
  output logic [BW-1:0]        RSP_DATA
`ifdef IF_UNIT_ARBITER_STATS_EN
  ,
  input  logic                 STATS_CLR,
  output logic [NREQ*16-1:0]   GRANT_CNT
`endif
);

  localparam int CNT_W = 4;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [AW-1:0]    op_a_q, op_a_d;
  logic [BW-1:0]    op_b_q, op_b_d;
  logic [AW-1:0]    unit_a_q, unit_a_d;
  logic [BW-1:0]    unit_b_q, unit_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [BW-1:0]    rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;

  rr_arbiter_core #(.NREQ(NREQ), .ID_W(ID_W)) u_core (
    .valid (REQ_VALID),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grants only in IDLE; gated by reset so REQ_READY reads 0 while held.
  assign REQ_READY = ((state_q == IDLE) && RST_N) ? pick_grant : '0;

  assign UNIT_A    = unit_a_q;
  assign UNIT_B    = unit_b_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_DATA  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        // A found winner always has REQ_READY and REQ_VALID high: transfer.
        if (pick_found) begin
          op_a_d  = REQ_A[int'(pick_idx)*AW +: AW];
          op_b_d  = REQ_B[int'(pick_idx)*BW +: BW];
          gid_d   = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unit_a_d = op_a_q;
        unit_b_d = op_b_q;
        cnt_d    = CNT_W'(UNIT_LAT);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d  = UNIT_XOUT;
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gid_q       <= gid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef IF_UNIT_ARBITER_STATS_EN
  logic [NREQ-1:0] accept;
  logic [15:0]     grant_cnt_q [NREQ];
  logic [15:0]     grant_cnt_d [NREQ];

  assign accept = REQ_READY & REQ_VALID;

  // Clear has priority over a same-cycle accept; counters stick at 16'hFFFF.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (STATS_CLR) begin
        grant_cnt_d[i] = '0;
      end else if (accept[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end
      GRANT_CNT[i*16 +: 16] = grant_cnt_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule
